// File: rtl/fixed_point_divider.sv
// fixed_point_divider: sequential radix-2 restoring divider computing
// result = (a << FRAC) / b in signed fixed point, constant latency.
// Optional build macro FIXED_POINT_DIVIDER_ROUND_EN selects round-half-
// away-from-zero of the magnitude instead of truncation toward zero.
module fixed_point_divider #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned DIV_W = 22,
  parameter int unsigned FRAC  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   a,
  input  logic [DIV_W-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W-1:0]   result,
  output logic              dbz,
  output logic              sat
);

  localparam int unsigned N  = IN_W + FRAC;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [N:0]      POS_LIM = (N+1)'((64'd1 << (IN_W - 1)) - 64'd1);
  localparam logic [N:0]      NEG_LIM = (N+1)'(64'd1 << (IN_W - 1));
  localparam logic [IN_W-1:0] MAX_V   = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MIN_V   = {1'b1, {(IN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t            state_q, state_d;
  logic              sign_q;
  logic [N-1:0]      dvd_q;
  logic [DIV_W-1:0]  b_q;
  logic [DIV_W:0]    rem_q;
  logic [N-1:0]      quo_q;
  logic [CW-1:0]     cnt_q;
  logic [IN_W-1:0]   result_q;
  logic              dbz_q, sat_q;

  logic              accept;
  logic [IN_W-1:0]   mag_in;
  logic [DIV_W:0]    rem_sh, rem_d;
  logic              q_bit;
  logic [N:0]        mag_r;
  logic [IN_W-1:0]   norm_res;
  logic              norm_dbz, norm_sat;

  assign accept = in_valid && (state_q == IDLE);

  // State register with synchronous reset that aborts any operation
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = DIV;
      DIV:  if (cnt_q == CW'(1)) state_d = NORM;
      NORM: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; result flags come from registers
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    dbz       = dbz_q;
    sat       = sat_q;
  end

  // One restoring iteration: shift in next dividend bit, subtract if it fits
  always_comb begin
    mag_in = a[IN_W-1] ? (~a + IN_W'(1)) : a;
    rem_sh = {rem_q[DIV_W-1:0], dvd_q[N-1]};
    q_bit  = (rem_sh >= {1'b0, b_q});
    rem_d  = q_bit ? (rem_sh - {1'b0, b_q}) : rem_sh;
  end

  // Normalisation: optional rounding, then saturation, then sign
  always_comb begin
    mag_r    = {1'b0, quo_q};
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    if ({rem_q, 1'b0} >= {2'b00, b_q}) mag_r = mag_r + (N+1)'(1);
`endif
    norm_dbz = 1'b0;
    norm_sat = 1'b0;
    if (b_q == '0) begin
      norm_dbz = 1'b1;
      norm_res = sign_q ? MIN_V : MAX_V;
    end else if (!sign_q && (mag_r > POS_LIM)) begin
      norm_sat = 1'b1;
      norm_res = MAX_V;
    end else if (sign_q && (mag_r > NEG_LIM)) begin
      norm_sat = 1'b1;
      norm_res = MIN_V;
    end else begin
      norm_res = sign_q ? (~mag_r[IN_W-1:0] + IN_W'(1)) : mag_r[IN_W-1:0];
    end
  end

  // Datapath registers: operand capture, iteration, result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q   <= 1'b0;
      dvd_q    <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          sign_q <= a[IN_W-1];
          dvd_q  <= {mag_in, {FRAC{1'b0}}};
          b_q    <= b;
          rem_q  <= '0;
          quo_q  <= '0;
          cnt_q  <= CW'(N);
        end
        DIV: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[N-2:0], 1'b0};
          quo_q <= {quo_q[N-2:0], q_bit};
          cnt_q <= cnt_q - CW'(1);
        end
        NORM: begin
          result_q <= norm_res;
          dbz_q    <= norm_dbz;
          sat_q    <= norm_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed vector bench for fixed_point_divider (defaults 32/22/15).
module tb_fixed_point_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [21:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        dbz;
  logic        sat;

  int checks   = 0;
  int failures = 0;

  fixed_point_divider #(.IN_W(32), .DIV_W(22), .FRAC(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .dbz(dbz), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [21:0] vb;
    logic [31:0] er;
    logic        ed;
    logic        es;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operand pair, wait for the result, complete the handshake
  task automatic run_op(input logic [31:0] ta, input logic [21:0] tb_,
                        output logic [31:0] r, output logic d, output logic s,
                        output int lat);
    @(negedge clk);
    a = ta; b = tb_; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; d = dbz; s = sat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[$];
  logic [31:0] r, r0;
  logic d, s;
  int lat;
  int seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  in_ready,  1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result",    result,    32'h0);
    check("reset_dbz",       dbz,       1'b0);
    check("reset_sat",       sat,       1'b0);
    rst = 1'b0;

    vecs.push_back('{32'h00018000, 22'h010000, 32'h0000C000, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFE8000, 22'h010000, 32'hFFFF4000, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 22'h008000, 32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{32'h00008000, 22'h000000, 32'h7FFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFF8000, 22'h000000, 32'h80000000, 1'b1, 1'b0});
    vecs.push_back('{32'h00000000, 22'h000000, 32'h7FFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 22'h000001, 32'h7FFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{32'h80000000, 22'h000001, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{32'h00010000, 22'h018000, 32'h00005555, 1'b0, 1'b0});
    vecs.push_back('{32'h00000000, 22'h000001, 32'h00000000, 1'b0, 1'b0});
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    vecs.push_back('{32'h00000001, 22'h010000, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 22'h010000, 32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF8000, 22'h018000, 32'hFFFFD555, 1'b0, 1'b0});
`else
    vecs.push_back('{32'h00000001, 22'h010000, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 22'h010000, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF8000, 22'h018000, 32'hFFFFD556, 1'b0, 1'b0});
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].va, vecs[i].vb, r, d, s, lat);
      check($sformatf("v%0d_result", i),  r,   vecs[i].er);
      check($sformatf("v%0d_dbz", i),     d,   vecs[i].ed);
      check($sformatf("v%0d_sat", i),     s,   vecs[i].es);
      check($sformatf("v%0d_latency", i), lat, 48);
      check($sformatf("v%0d_idle_after", i), {in_ready, out_valid}, 2'b10);
    end

    // Backpressure: hold out_ready low in DONE while offering a new operand
    @(negedge clk);
    a = 32'h00018000; b = 22'h010000; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h12345678; b = 22'h000003;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 48);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_result", k), result, 32'h0000C000);
      check($sformatf("bp_hold%0d_flags", k), {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {in_ready, out_valid}, 2'b10);
    run_op(32'hFFFE8000, 22'h010000, r, d, s, lat);
    check("bp_next_result", r, 32'hFFFF4000);
    check("bp_next_latency", lat, 48);

    // Reset mid-division: no result, then a normal operation
    @(negedge clk);
    a = 32'h00018000; b = 22'h010000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_flags",  {in_ready, out_valid}, 2'b10);
    check("abort_result", result, 32'h0);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_output", seen, 0);
    run_op(32'h00010000, 22'h018000, r, d, s, lat);
    check("abort_next_result", r, 32'h00005555);
    check("abort_next_latency", lat, 48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Sequential radix-2 restoring divider.
- Inverse of the constant-multiplier path: computes result = (a << FRAC) / b in signed Qx.FRAC.
- Used by dequantisation/rescale stages where dividing by a run-time quantisation step is needed instead of multiplying by a precomputed reciprocal.
- Valid/ready on both sides; one operation in flight; constant latency.

Parameters:
- IN_W, 32, width of dividend a and result (signed two's complement, FRAC fractional bits).
- DIV_W, 22, width of divisor b (unsigned, FRAC fractional bits).
- FRAC, 15, number of fractional bits shared by a, b and result.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  divider idle, can accept operands.
- a  input  IN_W  signed dividend.
- b  input  DIV_W  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  IN_W  signed quotient, Q(IN_W-FRAC).FRAC.
- dbz  output  1  divide-by-zero flag, qualified by out_valid.
- sat  output  1  saturation flag, qualified by out_valid.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, dbz=0, sat=0.
- Reset has priority in every state and aborts any operation mid-flight; no result is produced for an aborted operation.
- Let N = IN_W+FRAC (47 at defaults).
- FSM states: IDLE, DIV, NORM, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready (accept edge = edge 0).
  - At the accept edge: latch sign=a[IN_W-1], mag=|a| as IN_W-bit unsigned (|-2^(IN_W-1)| = 2^(IN_W-1), no overflow).
  - Also form the N-bit dividend {mag, FRAC zeros}, latch b, clear the remainder (DIV_W+1 bits), clear the quotient (N bits), load the iteration counter with N.
  - Go to DIV.
- DIV:
  - One quotient bit per cycle, MSB first.
  - rem' = {rem, next dividend bit}; if rem' >= b then subtract b and shift in quotient bit 1, else shift in 0.
  - Decrement the counter; after N iterations (edges 1..N) go to NORM.
  - If b==0, iterations still run (constant latency) and the quotient is discarded.
- NORM (edge N+1):
  - If b==0: dbz=1, sat=0; result=0x7FF..F for sign=0, 0x800..0 for sign=1 (0x7FFFFFFF for a=0 too).
  - Else, positive: if quotient > 2^(IN_W-1)-1, set result=max and sat=1.
  - Else, negative: if quotient > 2^(IN_W-1), set result=min and sat=1.
  - Otherwise result = sign ? -quotient : quotient, truncated toward zero.
  - out_valid set at this edge; go to DONE.
- DONE:
  - out_valid=1; result, dbz and sat held stable until out_valid&&out_ready; in_ready=0.
  - On handshake: out_valid=0, go to IDLE.
  - A new operand can be accepted no earlier than the cycle after the output handshake.
- Latency:
  - out_valid is visible after edge N+1 following the accept edge (48 cycles at defaults), independent of operands.
  - Throughput: at most one result per N+3 cycles with out_ready held high.
- in_valid while busy is ignored; the source must hold a and b stable until accepted.
- Inputs a and b are not sampled outside the accept edge.

Optional Feature:
- Macro: FIXED_POINT_DIVIDER_ROUND_EN.
- Defined: NORM rounds magnitude half away from zero before saturation; if 2*rem >= b, magnitude += 1, then the saturation check and sign apply. The comparison uses a DIV_W+2-bit compare. Latency unchanged.
- Undefined: truncation toward zero, remainder ignored.
- The dbz path is identical in both builds.

Test Plan:
- Basic: a=0x00018000 (3.0), b=0x010000 (2.0) -> result=0x0000C000 (1.5), dbz=0, sat=0; out_valid after exactly 48 edges from accept.
- Negative: a=0xFFFE8000 (-3.0), b=0x010000 -> result=0xFFFF4000 (-1.5); a=0x80000000, b=0x008000 (1.0) -> 0x80000000, sat=0.
- Divide by zero: a=0x00008000, b=0 -> result=0x7FFFFFFF, dbz=1; a=0xFFFF8000, b=0 -> 0x80000000, dbz=1; latency still 48.
- Saturation: a=0x7FFFFFFF, b=0x000001 -> result=0x7FFFFFFF, sat=1; a=0x80000000, b=0x000001 -> 0x80000000, sat=1.
- Rounding: a=0x00000001, b=0x010000 -> result=0x00000000 without macro, 0x00000001 with FIXED_POINT_DIVIDER_ROUND_EN; a=0xFFFFFFFF, same b -> 0 / 0xFFFFFFFF respectively.
- Handshake/reset:
  - Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, extra in_valid ignored.
  - Assert rst at DIV cycle 20 -> next cycle in_ready=1, out_valid=0, no result emitted; a following operation completes normally.
